// File: rtl/sc_frame_receiver.sv
// Rebuilds the MAROC slow-control frame from the oversampled CK_SC/D_SC serial lines,
// flags aborted or timed-out frames and compares each finished frame against a reference.
module sc_frame_receiver #(
  parameter int FRAME_BITS  = 829,
  parameter int TIMEOUT_CYC = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rstn_in,
  input  logic                  sc_clk_in,
  input  logic                  sc_data_in,
  input  logic                  sc_rstn_in,
  input  logic [FRAME_BITS-1:0] expected_in,
  input  logic                  clear_err_in,
  output logic [FRAME_BITS-1:0] frame_out,
  output logic [9:0]            dac1_out,
  output logic [9:0]            dac2_out,
  output logic                  frame_valid_out,
  output logic                  match_out,
  output logic                  err_timeout_out,
  output logic                  err_abort_out,
  output logic [9:0]            bit_count_out,
  output logic [1:0]            state_out
);

  localparam int TMO_W = (TIMEOUT_CYC < 256) ? 8 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECEIVING = 2'd1,
    DONE      = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  clk_sync, data_sync, rstn_sync;
  logic                    clk_prev;
  logic                    clk_s, data_s, rstn_s;
  logic                    take, last_bit, timed_out;
  logic [FRAME_BITS-1:0]   shift_q, next_shift;
  logic [9:0]              count_q;
  logic [TMO_W-1:0]        tmo_q;

  // All three serial lines share one synchronizer depth so data stays aligned with its clock edge.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      clk_sync  <= '0;
      data_sync <= '0;
      rstn_sync <= '0;
      clk_prev  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], sc_clk_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], sc_data_in};
      rstn_sync <= {rstn_sync[SYNC_STAGES-2:0], sc_rstn_in};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s      = clk_sync[SYNC_STAGES-1];
  assign data_s     = data_sync[SYNC_STAGES-1];
  assign rstn_s     = rstn_sync[SYNC_STAGES-1];
  assign take       = clk_s & ~clk_prev & rstn_s;
  assign next_shift = {data_s, shift_q[FRAME_BITS-1:1]};
  assign last_bit   = take && (state_q == RECEIVING) && (count_q == 10'(FRAME_BITS - 1));
  assign timed_out  = (state_q == RECEIVING) && !take && (tmo_q == TMO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (take) state_d = RECEIVING;
      RECEIVING: begin
        if (last_bit)       state_d = DONE;
        else if (timed_out) state_d = IDLE;
      end
      DONE:      state_d = take ? RECEIVING : IDLE;
      default:   state_d = IDLE;
    endcase
    if (!rstn_s) state_d = IDLE;
  end

  // frame_valid_out is a bare one-cycle strobe with no back-pressure: frame_out and match_out
  // are stable from that cycle until the next completed frame.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      shift_q         <= '0;
      count_q         <= '0;
      tmo_q           <= '0;
      frame_out       <= '0;
      frame_valid_out <= 1'b0;
      match_out       <= 1'b0;
    end else begin
      frame_valid_out <= 1'b0;
      if (!rstn_s) begin
        count_q <= '0;
        tmo_q   <= '0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            tmo_q <= '0;
            if (take) begin
              shift_q <= next_shift;
              count_q <= 10'd1;
            end else begin
              count_q <= '0;
            end
          end
          RECEIVING: begin
            if (take) begin
              shift_q <= next_shift;
              count_q <= count_q + 10'd1;
              tmo_q   <= '0;
              if (last_bit) begin
                frame_out       <= next_shift;
                frame_valid_out <= 1'b1;
                match_out       <= (next_shift == expected_in);
              end
            end else if (timed_out) begin
              count_q <= '0;
              tmo_q   <= '0;
            end else if (tmo_q != '1) begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          default: begin
            count_q <= '0;
            tmo_q   <= '0;
          end
        endcase
      end
    end
  end

  // A set event outranks a simultaneous clear so no error is ever lost.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      err_timeout_out <= 1'b0;
      err_abort_out   <= 1'b0;
    end else begin
      if (timed_out)         err_timeout_out <= 1'b1;
      else if (clear_err_in) err_timeout_out <= 1'b0;
      if (!rstn_s && (count_q != '0)) err_abort_out <= 1'b1;
      else if (clear_err_in)          err_abort_out <= 1'b0;
    end
  end

  assign dac1_out      = frame_out[22:13];
  assign dac2_out      = frame_out[12:3];
  assign bit_count_out = count_q;
  assign state_out     = state_q;

endmodule

// File: doc/sc_frame_receiver.md
Name: sc_frame_receiver

Overview:
- Deserializes the MAROC slow-control serial stream (data line plus slow-control bit clock) back into the 829-bit configuration frame.
- Used for readback/loopback checking of the slow-control transmitter and as the chip-side model in system benches.
- Oversamples the serial lines with the fast system clock, rebuilds the frame LSB-first and flags short frames.
- Compares each completed frame against an expected frame.

Parameters:
- FRAME_BITS, 829: bits per slow-control frame.
- TIMEOUT_CYC, 255: system-clock cycles without a serial clock edge, mid-frame, before the frame is aborted.
- SYNC_STAGES, 2: synchronizer depth on the serial inputs (minimum 2).

Ports:
- clk_in  in  1  system clock; must be at least 4x the serial clock frequency.
- rstn_in  in  1  asynchronous active-low reset.
- sc_clk_in  in  1  serial bit clock (CK_SC); asynchronous to clk_in.
- sc_data_in  in  1  serial data (D_SC); valid at the sc_clk_in rising edge.
- sc_rstn_in  in  1  frame abort, active-low; asynchronous.
- expected_in  in  FRAME_BITS  reference frame for comparison.
- clear_err_in  in  1  synchronous clear of sticky error flags.
- frame_out  out  FRAME_BITS  last complete frame; bit 0 is the first bit received.
- dac1_out  out  10  frame_out[22:13].
- dac2_out  out  10  frame_out[12:3].
- frame_valid_out  out  1  one-cycle pulse when frame_out updates.
- match_out  out  1  frame_out equals expected_in; updated with frame_valid_out.
- err_timeout_out  out  1  sticky: frame aborted by timeout.
- err_abort_out  out  1  sticky: frame aborted by sc_rstn_in.
- bit_count_out  out  10  bits received in the current frame.
- state_out  out  2  current FSM state.

Behaviour:
- Reset: rstn_in is asynchronous and active-low.
  - While low, all outputs, the shift register, counters and synchronizers are 0.
  - state_out = IDLE (0).
- Input conditioning:
  - sc_clk_in, sc_data_in and sc_rstn_in each pass through SYNC_STAGES flops.
  - A rising edge is the synchronized clock high while its previous registered value is low.
  - Data is taken from the synchronized data stage aligned with the edge.
  - Falling edges are ignored.
- Shift: on each detected edge, buffer <= {data, buffer[FRAME_BITS-1:1]}. After FRAME_BITS edges, bit 0 holds the first bit received.
- State IDLE (0):
  - bit count = 0.
  - A first edge with synchronized sc_rstn high shifts in bit 1, sets count = 1 and moves to RECEIVING.
- State RECEIVING (1):
  - Each edge increments the count; the timeout counter clears on every edge.
  - The edge that makes count == FRAME_BITS moves to DONE.
  - If the timeout counter reaches TIMEOUT_CYC with no edge: set err_timeout_out, discard the frame, go to IDLE.
- State DONE (2): lasts exactly one cycle, then IDLE with count = 0.
  - Latency: frame_out, dac1_out, dac2_out and match_out update, and frame_valid_out = 1, in the cycle after the last edge is detected.
  - An edge detected during DONE is the first bit of the next frame and goes to RECEIVING with count = 1.
- Abort: synchronized sc_rstn low in any state forces IDLE and clears count and timeout.
  - err_abort_out is set only if count was nonzero.
  - Edges are ignored while sc_rstn is low.
- Persistence: frame_out and match_out hold until the next complete frame. Aborted or timed-out frames never modify them.
- Sticky flags: clear_err_in clears both flags. A set event in the same cycle as clear_err_in wins, so the flag stays 1.
- The timeout counter is 8 bits minimum and saturates; it never wraps.
- State encoding 3 is unused and recovers to IDLE on the next clock.

Test Plan:
- Frame capture: reset, then send 829 bits with bit0 = 1, DAC2 = 0x155, DAC1 = 0x2AA, rest 0, serial clock at clk/8.
  - Exactly one frame_valid_out pulse.
  - frame_out[0] = 1, dac2_out = 0x155, dac1_out = 0x2AA.
  - bit_count_out returns to 0; state sequence 1 -> 2 -> 0.
- Match: expected_in = sent frame gives match_out = 1. Flip sent bit 500 and resend: match_out = 0, frame_valid_out still pulses.
- Short frame: send 400 bits, then idle for 300 cycles.
  - err_timeout_out = 1 at 255 idle cycles; no frame_valid_out; frame_out unchanged.
  - clear_err_in clears the flag.
- Abort: drive sc_rstn_in low after 100 bits.
  - err_abort_out = 1, state IDLE.
  - Then a full 829-bit frame captures correctly.
- Back-to-back: two frames with no gap (0xFF pattern, then all-zero).
  - Two valid pulses; second frame_out is all zero; no errors.
- Reset mid-frame: assert rstn_in at bit 600. All outputs are 0 immediately; the next full frame is received correctly.
